// File: rtl/io_uart_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_uart_target: memory-mapped 8N1 UART bus target, programmable divisor.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module io_uart_target #(
    parameter logic [15:0] BASE        = 16'hC000,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [9:0]  rdata,
    input  logic        rxd,
    output logic        txd
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV_LO = 2'd2;
    localparam logic [1:0] REG_DIV_HI = 2'd3;

    logic [15:0] div;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        ovr;
    logic        ferr;

    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    logic        hit;
    logic        pop;
    logic        data_wr;
    logic        status_wr;
    logic        tx_ready;
    logic        rx_fall;
    logic        rx_deliver;
    logic        rx_drop;
    logic [15:0] rx_half;
    logic [15:0] rx_half_load;
    logic        unused_wdata;

    assign hit        = (addr[15:2] == BASE[15:2]);
    assign pop        = re & hit & (addr[1:0] == REG_DATA);
    assign data_wr    = we & hit & (addr[1:0] == REG_DATA);
    assign status_wr  = we & hit & (addr[1:0] == REG_STATUS);
    assign tx_ready   = (tx_state == ST_IDLE);
    assign rx_fall    = rx_prev & ~rx_sync;
    assign rx_deliver = (rx_state == ST_STOP) && (rx_cnt == 16'd0);
    assign rx_drop    = rx_valid & ~pop;
    assign rx_half    = {1'b0, div[15:1]};
    // The edge is seen one cycle into the start bit, so the half-bit count is one short.
    assign rx_half_load = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;
    assign unused_wdata = ^wdata[15:8];

    always_comb begin
        rdata = 10'd0;
        if (re && hit) begin
            case (addr[1:0])
                REG_DATA:   rdata = {2'b00, rx_byte};
                REG_STATUS: rdata = {6'b0, ferr, ovr, tx_ready, rx_valid};
                REG_DIV_LO: rdata = {2'b00, div[7:0]};
                default:    rdata = {2'b00, div[15:8]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= DEFAULT_DIV;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (we && hit && addr[1:0] == REG_DIV_LO) div[7:0]  <= wdata[7:0];
            if (we && hit && addr[1:0] == REG_DIV_HI) div[15:8] <= wdata[7:0];

            if (rx_deliver && !rx_drop) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end

            if (rx_deliver && rx_drop)        ovr <= 1'b1;
            else if (status_wr && wdata[2])   ovr <= 1'b0;

            if (rx_deliver && !rx_sync)       ferr <= 1'b1;
            else if (status_wr && wdata[3])   ferr <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (data_wr) begin
                        tx_state <= ST_START;
                        tx_cnt   <= div;
                        tx_shift <= wdata[7:0];
                        txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= div;
                        tx_bit   <= 3'd0;
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) tx_state <= ST_IDLE;
                    else                 tx_cnt   <= tx_cnt - 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                        rx_cnt   <= rx_half_load;
                    end
                end
                ST_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_sync) begin
                            rx_state <= ST_DATA;
                            rx_cnt   <= div;
                            rx_bit   <= 3'd0;
                        end else begin
                            rx_state <= ST_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= div;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    // Back to idle straight after the stop sample, not at the end of the stop bit.
                    if (rx_cnt == 16'd0) rx_state <= ST_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_target.sv
`default_nettype none
// Self-checking bench for io_uart_target: register table, serial TX/RX against a frame model.
module tb_io_uart_target;
    localparam logic [15:0] BASE = 16'hC000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic [9:0]  rdata;
    logic        rxd;
    logic        txd;

    int checks   = 0;
    int failures = 0;
    logic [9:0] d;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [15:0] dat;
        logic [9:0]  exp;
    } vec_t;
    vec_t vt[13];

    io_uart_target #(.BASE(BASE), .DEFAULT_DIV(16'd433)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we),
        .wdata(wdata), .rdata(rdata), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] dat);
        @(negedge clk);
        addr = a; wdata = dat; we = 1'b1; re = 1'b0;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [9:0] q);
        @(negedge clk);
        addr = a; re = 1'b1; we = 1'b0;
        #1 q = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic set_div(input int dv);
        logic [15:0] v;
        v = dv[15:0];
        bus_write(BASE + 16'd2, {8'h00, v[7:0]});
        bus_write(BASE + 16'd3, {8'h00, v[15:8]});
    endtask

    // Expected line level at cycle i of a frame: bit i/(div+1) of {stop, byte, start}, idle afterwards.
    task automatic tx_check(input logic [7:0] b, input int dv, input int second_at);
        logic [9:0] bits;
        int total;
        bits  = {1'b1, b, 1'b0};
        total = 10 * (dv + 1);
        bus_write(BASE, {8'h00, b});
        for (int i = 0; i <= total; i++) begin
            if (i > 0) @(negedge clk);
            we = 1'b0;
            if (i == second_at) begin
                addr = BASE; wdata = 16'h003C; we = 1'b1; re = 1'b0;
                #1 check("tx_line", {15'd0, txd}, {15'd0, bits[i / (dv + 1)]});
            end else begin
                addr = BASE + 16'd1; re = 1'b1;
                #1;
                check("tx_line", {15'd0, txd}, (i < total) ? {15'd0, bits[i / (dv + 1)]} : 16'd1);
                check("tx_ready", {15'd0, rdata[1]}, (i >= total) ? 16'd1 : 16'd0);
            end
        end
        re = 1'b0; we = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int dv);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd = f[k];
            repeat (dv) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic rx_round(input logic [7:0] b, input logic stop, input int dv);
        logic [9:0] q;
        send_frame(b, stop, dv);
        bus_read(BASE + 16'd1, q);
        check("rx_status", {6'd0, q}, {12'd0, ~stop, 1'b0, 1'b1, 1'b1});
        bus_read(BASE, q);
        check("rx_data", {6'd0, q}, {8'd0, b});
        bus_write(BASE + 16'd1, 16'h000C);
    endtask

    initial begin
        rst = 1'b1; addr = 16'h0; re = 1'b0; we = 1'b0; wdata = 16'h0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        addr = BASE + 16'd1;
        #1;
        check("reset_txd", {15'd0, txd}, 16'd1);
        check("reset_rdata_re0", {6'd0, rdata}, 16'd0);
        rst = 1'b0;

        vt[0]  = '{1'b0, BASE + 16'd1, 16'h0000, 10'h002};
        vt[1]  = '{1'b0, BASE + 16'd2, 16'h0000, 10'h0B1};
        vt[2]  = '{1'b0, BASE + 16'd3, 16'h0000, 10'h001};
        vt[3]  = '{1'b0, BASE,         16'h0000, 10'h000};
        vt[4]  = '{1'b0, BASE + 16'd4, 16'h0000, 10'h000};
        vt[5]  = '{1'b0, 16'h0001,     16'h0000, 10'h000};
        vt[6]  = '{1'b1, BASE + 16'd2, 16'hFF5A, 10'h000};
        vt[7]  = '{1'b0, BASE + 16'd2, 16'h0000, 10'h05A};
        vt[8]  = '{1'b1, BASE + 16'd3, 16'h0012, 10'h000};
        vt[9]  = '{1'b0, BASE + 16'd3, 16'h0000, 10'h012};
        vt[10] = '{1'b0, BASE + 16'd2, 16'h0000, 10'h05A};
        vt[11] = '{1'b1, BASE + 16'd1, 16'h000C, 10'h000};
        vt[12] = '{1'b0, BASE + 16'd1, 16'h0000, 10'h002};
        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr) begin
                bus_write(vt[i].a, vt[i].dat);
            end else begin
                bus_read(vt[i].a, d);
                check($sformatf("vec%0d", i), {6'd0, d}, {6'd0, vt[i].exp});
            end
        end

        // TX: fixed frame with a dropped mid-frame write, then random bytes and divisors.
        set_div(3);
        tx_check(8'hA5, 3, 6);
        for (int r = 0; r < 3; r++) begin
            int dv;
            logic [7:0] b;
            dv = $urandom_range(0, 5);
            b  = 8'($urandom);
            set_div(dv);
            tx_check(b, dv, -1);
        end

        // RX: clean frame, non-popping decode miss, pop clears rx_valid.
        set_div(7);
        send_frame(8'h3C, 1'b1, 7);
        bus_read(BASE + 16'd1, d); check("rx_valid_set", {6'd0, d}, 16'h003);
        bus_read(BASE + 16'd4, d); check("nodecode_read", {6'd0, d}, 16'h000);
        bus_read(BASE + 16'd1, d); check("nodecode_nopop", {6'd0, d}, 16'h003);
        bus_read(BASE, d);         check("rx_data_3c", {6'd0, d}, 16'h03C);
        bus_read(BASE + 16'd1, d); check("rx_popped", {6'd0, d}, 16'h002);

        // Framing error still delivers the byte.
        send_frame(8'h5A, 1'b0, 7);
        bus_read(BASE + 16'd1, d); check("ferr_status", {6'd0, d}, 16'h00B);
        bus_read(BASE, d);         check("ferr_data", {6'd0, d}, 16'h05A);
        bus_write(BASE + 16'd1, 16'h000C);
        bus_read(BASE + 16'd1, d); check("ferr_cleared", {6'd0, d}, 16'h002);

        // Three-cycle glitch is a false start.
        @(negedge clk); rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(BASE + 16'd1, d); check("glitch_status", {6'd0, d}, 16'h002);

        // Overrun keeps the first byte.
        send_frame(8'h11, 1'b1, 7);
        send_frame(8'h22, 1'b1, 7);
        bus_read(BASE + 16'd1, d); check("ovr_status", {6'd0, d}, 16'h007);
        bus_read(BASE, d);         check("ovr_data", {6'd0, d}, 16'h011);
        bus_write(BASE + 16'd1, 16'h000C);
        bus_read(BASE + 16'd1, d); check("ovr_cleared", {6'd0, d}, 16'h002);

        // Pop on the stop-sample cycle: stop sample is (2 + div/2 + 9*(div+1)) edges after the pin falls.
        send_frame(8'h11, 1'b1, 7);
        @(negedge clk);
        fork
            send_frame(8'h22, 1'b1, 7);
            begin
                logic [9:0] q;
                @(negedge clk);
                repeat (2 + 3 + 9 * 8) @(posedge clk);
                @(negedge clk);
                addr = BASE; re = 1'b1;
                #1 q = rdata;
                check("coincide_old", {6'd0, q}, 16'h011);
                @(negedge clk);
                re = 1'b0;
            end
        join
        bus_read(BASE + 16'd1, d); check("coincide_status", {6'd0, d}, 16'h003);
        bus_read(BASE, d);         check("coincide_data", {6'd0, d}, 16'h022);
        bus_read(BASE + 16'd1, d); check("coincide_empty", {6'd0, d}, 16'h002);

        for (int r = 0; r < 4; r++) begin
            int dv;
            logic [7:0] b;
            logic stop;
            dv   = $urandom_range(3, 10);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            set_div(dv);
            rx_round(b, stop, dv);
        end

        // Reset during TX data bit 3 forces the line high without a clock edge.
        set_div(3);
        bus_write(BASE, 16'h0000);
        repeat (17) @(negedge clk);
        #1 check("pre_reset_txd", {15'd0, txd}, 16'd0);
        rst = 1'b1;
        #1 check("async_reset_txd", {15'd0, txd}, 16'd1);
        addr = BASE + 16'd1; re = 1'b1;
        #1 check("reset_tx_ready", {6'd0, rdata}, 16'h002);
        @(negedge clk);
        rst = 1'b0; re = 1'b0;
        bus_read(BASE + 16'd2, d); check("reset_div_lo", {6'd0, d}, 16'h0B1);
        #1 check("post_reset_txd", {15'd0, txd}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/io_uart_target.md
# io_uart_target

Memory-mapped UART peripheral that responds to the CPU's external I/O bus (any access with `addr[15:13] != 0`, qualified into `re`/`we` by the CPU). It is the bus target at the far end of the CPU's `addr`/`we`/`re`/`wdata`/`rdata` port. The bootloader uses it to receive program bytes and send status bytes over a serial line: 8 data bits, no parity, 1 stop bit (8N1), LSB first, with a programmable baud divisor. Read data returns combinationally in the same cycle the CPU samples it.

## Interface
- `BASE`, 16'hC000: word-aligned base address. The block decodes `addr[15:2] == BASE[15:2]`.
- `DEFAULT_DIV`, 16'd433: divisor reset value. Bit period is `div+1` clocks.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `addr` in 16: bus address. `addr[1:0]` selects the register.
- `re` in 1: read strobe, already qualified by the CPU.
- `we` in 1: write strobe, already qualified by the CPU.
- `wdata` in 16: write data. Only `[7:0]` is used.
- `rdata` out 10: read data. Combinational.
- `rxd` in 1: serial input, asynchronous to `clk`.
- `txd` out 1: serial output, registered, idles high.

## Operation
- Register map, selected by `addr[1:0]` when decoded:
  - 0 DATA
    - Read returns `{2'b0, rx_byte}`. A read pops: `rx_valid` clears at the edge.
    - Write loads `wdata[7:0]` into TX if `tx_ready`. A write while busy is dropped silently.
  - 1 STATUS
    - Read returns `{6'b0, ferr, ovr, tx_ready, rx_valid}`.
    - Write-1-to-clear: `wdata[2]` clears `ovr`, `wdata[3]` clears `ferr`.
  - 2 DIV_LO: R/W `div[7:0]`. Read returns it zero-extended.
  - 3 DIV_HI: R/W `div[15:8]`. Read returns it zero-extended.
- `rdata` is 0 whenever `re` is 0 or the address does not decode. Read side effects require `re` plus a decoded address.
- `re` and `we` in the same cycle: both are honored independently.
- TX FSM, states IDLE → START → DATA(bit 0..7) → STOP → IDLE:
  - Every state after IDLE lasts exactly `div+1` clocks, counted by a bit-period counter reloaded from `div` at each bit boundary.
  - `tx_ready` is 1 only in IDLE.
- RX FSM, states IDLE → START → DATA(bit 0..7) → STOP → IDLE:
  - `rxd` passes through a 2-flop synchronizer. Edge detection compares the synchronized bit with its previous value.
  - IDLE: a falling edge moves to START and loads the counter with `div>>1`.
  - START, at the half-bit point: if the line is still low, go to DATA and reload with `div`. If it is high, it is a false start: return to IDLE, no flags change.
  - DATA: sample at each full period, shifting in LSB first.
  - STOP: sample.
    - Sampled 0 sets `ferr`; the byte is still delivered.
    - Delivery: if `rx_valid` is already 1 and no pop occurs in the same cycle, the new byte is dropped, `ovr` is set, and the old byte is kept.
    - If a pop coincides with delivery, the new byte loads, `rx_valid` stays 1, and `ovr` is unchanged.
  - The FSM returns to IDLE right after the stop sample. It does not wait for the full stop period.
- `div` written mid-frame takes effect at the next bit boundary. `div` values below 2 are legal but out of spec for RX. Sampling behavior there is undefined; there must be no lockup.
- Counter and shift widths: counter 16 bits, shift registers 8 bits, no wrap. The counter counts down to 0, then reloads.

## Timing
- Reset values: `txd`=1, `rdata`=0 (with `re`=0), `rx_valid`=0, `tx_ready`=1, `ovr`=0, `ferr`=0, `div`=`DEFAULT_DIV`, `rx_byte`=0, both FSMs in IDLE.
- Reset mid-frame aborts immediately. `txd` goes high asynchronously and no partial byte is delivered.
- Read latency is 0 cycles: `rdata` is valid in the same cycle as `re`. The pop happens at the next rising edge.
- TX: a DATA write sampled at edge N gives `tx_ready`=0 after N. `txd` goes low from N (registered). The frame lasts 10×(`div`+1) cycles. `tx_ready`=1 again `10·(div+1)` cycles after N.
- RX sample points: relative to the first synchronized low cycle, data bit k is sampled at `(div>>1) + (k+1)(div+1)` cycles. This is plus 2 cycles of synchronizer latency from the `rxd` pin.
- `rx_valid` rises 1 cycle after the stop-bit sample.

## Test plan
- Reset: assert `rst`, then release. Expect `txd`=1, STATUS read returns 10'h002, DIV_LO reads 10'h0B1, DIV_HI reads 10'h001.
- TX with `div`=3: write 8'hA5 to DATA.
  - `txd` sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - STATUS bit1=0 during the frame, and bit1=1 exactly 40 cycles after the write.
  - A second write mid-frame is ignored, so the serial output is unchanged.
- RX with `div`=7: drive a 0x3C frame at 8 cycles/bit. `rx_valid`=1 after the stop sample, DATA reads 10'h03C, and the next STATUS read shows bit0=0.
- RX errors:
  - Drive a frame with stop bit = 0: `ferr`=1 and the byte is delivered.
  - Drive a 3-cycle low glitch: no byte and no flags.
  - Write 10'h00C to STATUS: both flags clear.
- Overrun: receive 0x11 then 0x22 without reading. Expect `ovr`=1 and DATA reads 0x11. Repeat with the pop landing on the exact cycle of the second delivery: DATA then reads 0x22 and `ovr`=0.
- Decode plus async reset: reads at `BASE+4` return 0 with no pop. Assert `rst` during TX bit 3: `txd`=1 immediately and `tx_ready`=1.
